atomic_mem_arbiter: RTL

ATOMIC_MEM_ARBITER -- requirements
Module: atomic_mem_arbiter

---
 rtl/atomic_mem_arbiter_if.sv | 32 +++
 rtl/atomic_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/atomic_mem_arbiter_if.sv
// Signal bundle between two cores' fetch/data ports, the shared RAM and the arbiter.
// The arbiter uses the slave modport; the core/RAM side uses the master modport.
interface atomic_mem_arbiter_if;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0]        datomic;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][31:0]  iload;
    logic [1:0][31:0]  dload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;
    logic              merr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );
endinterface

// File: rtl/atomic_mem_arbiter.sv
// Two-core arbiter onto one shared RAM: data beats instruction, round-robin within a class,
// with per-core LL/SC link registers invalidated by any completed write to the same word.
module atomic_mem_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    atomic_mem_arbiter_if.slave io_bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_grantCore;
    logic              r_grantData;
    logic              r_rrPtr;
    logic [1:0]        r_linkValid;
    logic [1:0][29:0]  r_linkAddr;

    logic [1:0]        w_dReq;
    logic [1:0]        w_classReq;
    logic              w_pickCore;
    logic              w_pickData;
    logic [29:0]       w_grantWord;
    logic              w_isSc;
    logic              w_linkHit;
    logic              w_scFail;
    logic              w_ramEnd;
    logic              w_ramErr;
    logic              w_done;
    logic              w_linkSet;
    logic              w_writeDone;

    logic [1:0]        w_iwait;
    logic [1:0]        w_dwait;
    logic [1:0][31:0]  w_iload;
    logic [1:0][31:0]  w_dload;
    logic              w_ramREN;
    logic              w_ramWEN;
    logic [31:0]       w_ramaddr;
    logic [31:0]       w_ramstore;
    logic              w_merr;

    // Data requests shadow instruction requests entirely; the pointer only breaks ties within a class.
    assign w_dReq      = io_bus.dREN | io_bus.dWEN;
    assign w_pickData  = |w_dReq;
    assign w_classReq  = w_pickData ? w_dReq : io_bus.iREN;
    assign w_pickCore  = (w_classReq == 2'b11) ? r_rrPtr : w_classReq[1];

    assign w_grantWord = io_bus.daddr[r_grantCore][31:2];
    assign w_isSc      = io_bus.dWEN[r_grantCore] & io_bus.datomic[r_grantCore];
    assign w_linkHit   = r_linkValid[r_grantCore] && (r_linkAddr[r_grantCore] == w_grantWord);
    assign w_scFail    = w_isSc & ~w_linkHit;
    assign w_ramErr    = (io_bus.ramstate == RAM_ERROR);
    assign w_ramEnd    = (io_bus.ramstate == RAM_ACCESS) | w_ramErr;

    always_comb begin
        w_nextState = r_state;
        w_iwait     = io_bus.iREN;
        w_dwait     = w_dReq;
        w_iload     = '0;
        w_dload     = '0;
        w_ramREN    = 1'b0;
        w_ramWEN    = 1'b0;
        w_ramaddr   = '0;
        w_ramstore  = '0;
        w_merr      = 1'b0;
        w_done      = 1'b0;
        w_linkSet   = 1'b0;
        w_writeDone = 1'b0;
        if (i_rst) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_classReq) w_nextState = GRANT;
                end
                GRANT: begin
                    if (r_grantData) begin
                        // A failing SC never reaches the RAM and retires immediately.
                        if (w_scFail) begin
                            w_done                = 1'b1;
                            w_dwait[r_grantCore]  = 1'b0;
                        end else begin
                            w_ramREN   = io_bus.dREN[r_grantCore];
                            w_ramWEN   = io_bus.dWEN[r_grantCore];
                            w_ramaddr  = io_bus.daddr[r_grantCore];
                            w_ramstore = io_bus.dstore[r_grantCore];
                            if (w_ramEnd) begin
                                w_done               = 1'b1;
                                w_dwait[r_grantCore] = 1'b0;
                                if (w_ramErr) begin
                                    w_merr = 1'b1;
                                end else begin
                                    w_dload[r_grantCore] = w_isSc ? 32'd1 : io_bus.ramload;
                                    w_writeDone          = io_bus.dWEN[r_grantCore];
                                    w_linkSet            = io_bus.dREN[r_grantCore] & io_bus.datomic[r_grantCore];
                                end
                            end
                        end
                    end else begin
                        w_ramREN  = 1'b1;
                        w_ramaddr = io_bus.iaddr[r_grantCore];
                        if (w_ramEnd) begin
                            w_done               = 1'b1;
                            w_iwait[r_grantCore] = 1'b0;
                            if (w_ramErr) w_merr = 1'b1;
                            else          w_iload[r_grantCore] = io_bus.ramload;
                        end
                    end
                    if (w_done) w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grantCore <= 1'b0;
            r_grantData <= 1'b0;
            r_rrPtr     <= RR_INIT;
        end else begin
            if (r_state == IDLE && (|w_classReq)) begin
                r_grantCore <= w_pickCore;
                r_grantData <= w_pickData;
            end
            if (w_done) r_rrPtr <= ~r_rrPtr;
        end
    end

    // Any completed write kills every link on that word, the writer's own included.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_linkValid <= '0;
            r_linkAddr  <= '0;
        end else if (w_linkSet) begin
            r_linkValid[r_grantCore] <= 1'b1;
            r_linkAddr[r_grantCore]  <= w_grantWord;
        end else if (w_writeDone) begin
            for (int c = 0; c < 2; c++) begin
                if (r_linkAddr[c] == w_grantWord) r_linkValid[c] <= 1'b0;
            end
        end
    end

    assign io_bus.iwait    = w_iwait;
    assign io_bus.dwait    = w_dwait;
    assign io_bus.iload    = w_iload;
    assign io_bus.dload    = w_dload;
    assign io_bus.ramREN   = w_ramREN;
    assign io_bus.ramWEN   = w_ramWEN;
    assign io_bus.ramaddr  = w_ramaddr;
    assign io_bus.ramstore = w_ramstore;
    assign io_bus.merr     = w_merr;
endmodule
